// File: rtl/scv_pkg.sv
// Shared types, region limits and helpers for the ROMINIT download sequencer.
package scv_pkg;

  typedef enum logic [1:0] {
    RGN_BOOT = 2'd0,
    RGN_CHR  = 2'd1,
    RGN_CART = 2'd2
  } rominit_region_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } rominit_state_e;

  localparam int BYTE_CNT_W = 18;

  localparam logic [BYTE_CNT_W-1:0] ROM_LIMIT_BOOT = 18'd4096;
  localparam logic [BYTE_CNT_W-1:0] ROM_LIMIT_CHR  = 18'd4096;
  localparam logic [BYTE_CNT_W-1:0] ROM_LIMIT_CART = 18'd131072;

  localparam int CART_AW_MIN = 12;
  localparam int CART_AW_MAX = 17;

  localparam logic [4:0] CFG_AW_RESET = 5'd13;

  function automatic logic [BYTE_CNT_W-1:0] region_limit(input rominit_region_e rgn);
    logic [BYTE_CNT_W-1:0] lim;
    case (rgn)
      RGN_BOOT: lim = ROM_LIMIT_BOOT;
      RGN_CHR:  lim = ROM_LIMIT_CHR;
      default:  lim = ROM_LIMIT_CART;
    endcase
    return lim;
  endfunction

  // Smallest width in CART_AW_MIN..CART_AW_MAX whose span covers the byte count.
  function automatic logic [4:0] cart_aw(input logic [BYTE_CNT_W-1:0] nbytes);
    logic [4:0] aw;
    aw = 5'(CART_AW_MAX);
    for (int i = CART_AW_MAX; i >= CART_AW_MIN; i--) begin
      if (nbytes <= (18'd1 << i)) aw = 5'(i);
    end
    return aw;
  endfunction

endpackage

// File: rtl/scv_sync_fifo.sv
// Small synchronous FIFO buffering host bytes; reset flushes every entry.
module scv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && (count_q != (PTR_W+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/scv_rominit.sv
// ROMINIT download sequencer: buffers host bytes, replays them as paced addressed
// write strobes, holds the console in reset across the load and sizes the cart ROM.
module scv_rominit
  import scv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_SPACING  = 2,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        DL_START,
  input  logic [1:0]  DL_INDEX,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_VALID,
  output logic        DL_READY,
  input  logic        DL_END,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic [4:0]  CFG_ROM_AW,
  output logic        SYS_RESB,
  output logic        BUSY,
  output logic        ERR
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SP_W   = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  rominit_state_e         state_q, state_d;
  rominit_region_e        region_q, region_d;
  logic [24:0]            addr_q, addr_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic                   err_q, err_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [SP_W-1:0]        space_q, space_d;
  logic                   rom_valid_q, rom_valid_d;
  logic [24:0]            rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic [4:0]             cfg_aw_q, cfg_aw_d;
  logic                   dl_ready_q, dl_ready_d;
  logic                   busy_q, busy_d;
  logic                   sys_resb_q, sys_resb_d;
  logic [2:0]             sel_q, sel_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]             fifo_rdata;
  logic [CNT_W-1:0]       fifo_count, fifo_level_next;
  logic                   accept, engine_on;

  scv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RES),
    .push  (fifo_push),
    .wdata (DL_DATA),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    hold_cnt_d  = hold_cnt_q;
    space_d     = space_q;
    rom_valid_d = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    cfg_aw_d    = cfg_aw_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    sel_d       = 3'b000;

    // READY is only ever high while loading, so it doubles as the LOAD qualifier.
    accept    = DL_VALID && dl_ready_q;
    engine_on = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

    if (space_q != '0) space_d = space_q - SP_W'(1);

    if (engine_on && !fifo_empty && (space_q == '0)) begin
      fifo_pop    = 1'b1;
      rom_valid_d = 1'b1;
      rom_addr_d  = addr_q;
      rom_data_d  = fifo_rdata;
      addr_d      = addr_q + 25'd1;
      space_d     = SP_W'(WR_SPACING - 1);
    end

    // Bytes past the region limit are swallowed so the host stream never stalls.
    if (accept) begin
      if (byte_cnt_q < region_limit(region_q)) begin
        fifo_push  = !fifo_full;
        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (DL_START) begin
          if (DL_INDEX == 2'd3) begin
            err_d = 1'b1;
          end else begin
            region_d   = rominit_region_e'(DL_INDEX);
            addr_d     = '0;
            byte_cnt_d = '0;
            err_d      = 1'b0;
            space_d    = '0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (DL_END) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
          if ((region_q == RGN_CART) && (byte_cnt_q != '0)) cfg_aw_d = cart_aw(byte_cnt_q);
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_IDLE;
        else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_level_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    dl_ready_d = (state_d == ST_LOAD) && (fifo_level_next != CNT_W'(FIFO_DEPTH));
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    sys_resb_d = (state_d == ST_IDLE);
    if (busy_d) begin
      case (region_d)
        RGN_BOOT: sel_d = 3'b001;
        RGN_CHR:  sel_d = 3'b010;
        default:  sel_d = 3'b100;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= ST_HOLD;
      region_q    <= RGN_BOOT;
      addr_q      <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      hold_cnt_q  <= HOLD_W'(HOLD_CYCLES - 1);
      space_q     <= '0;
      rom_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      cfg_aw_q    <= CFG_AW_RESET;
      dl_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sys_resb_q  <= 1'b0;
      sel_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      hold_cnt_q  <= hold_cnt_d;
      space_q     <= space_d;
      rom_valid_q <= rom_valid_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      cfg_aw_q    <= cfg_aw_d;
      dl_ready_q  <= dl_ready_d;
      busy_q      <= busy_d;
      sys_resb_q  <= sys_resb_d;
      sel_q       <= sel_d;
    end
  end

  assign DL_READY         = dl_ready_q;
  assign ROMINIT_SEL_BOOT = sel_q[0];
  assign ROMINIT_SEL_CHR  = sel_q[1];
  assign ROMINIT_SEL_CART = sel_q[2];
  assign ROMINIT_ADDR     = rom_addr_q;
  assign ROMINIT_DATA     = rom_data_q;
  assign ROMINIT_VALID    = rom_valid_q;
  assign CFG_ROM_AW       = cfg_aw_q;
  assign SYS_RESB         = sys_resb_q;
  assign BUSY             = busy_q;
  assign ERR              = err_q;

endmodule

// File: tb/tb_scv_rominit.sv
// Directed-plus-random bench for scv_rominit with a queue-based model of the expected strobes.
module tb_scv_rominit;

  localparam int FIFO_DEPTH  = 4;
  localparam int WR_SPACING  = 2;
  localparam int HOLD_CYCLES = 64;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        DL_START = 1'b0;
  logic [1:0]  DL_INDEX = 2'd0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        DL_VALID = 1'b0;
  logic        DL_END = 1'b0;
  logic        DL_READY;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic [4:0]  CFG_ROM_AW;
  logic        SYS_RESB, BUSY, ERR;

  int n_pass = 0;
  int n_total = 0;

  int          cyc = 0;
  int          last_res_cyc = 0;
  int          rise_cyc = 0;
  int          sel_fall_cyc = 0;
  logic        prev_resb = 1'b0;
  logic [2:0]  prev_sel = 3'b000;
  logic [24:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  logic [2:0]  obs_sel[$];
  int          obs_cyc[$];

  logic [7:0]  tx[$];
  int          cur_cfg = 13;
  int          sent, max_stall, first_acc_cyc;

  scv_rominit #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .WR_SPACING  (WR_SPACING),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .CLK              (CLK),
    .RES              (RES),
    .DL_START         (DL_START),
    .DL_INDEX         (DL_INDEX),
    .DL_DATA          (DL_DATA),
    .DL_VALID         (DL_VALID),
    .DL_READY         (DL_READY),
    .DL_END           (DL_END),
    .ROMINIT_SEL_BOOT (ROMINIT_SEL_BOOT),
    .ROMINIT_SEL_CHR  (ROMINIT_SEL_CHR),
    .ROMINIT_SEL_CART (ROMINIT_SEL_CART),
    .ROMINIT_ADDR     (ROMINIT_ADDR),
    .ROMINIT_DATA     (ROMINIT_DATA),
    .ROMINIT_VALID    (ROMINIT_VALID),
    .CFG_ROM_AW       (CFG_ROM_AW),
    .SYS_RESB         (SYS_RESB),
    .BUSY             (BUSY),
    .ERR              (ERR)
  );

  always #5 CLK = ~CLK;

  // Records strobes and reset/select edges just after each rising edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (RES) last_res_cyc = cyc;
    if (SYS_RESB === 1'b1 && prev_resb !== 1'b1) rise_cyc = cyc;
    prev_resb = SYS_RESB;
    if (prev_sel != 3'b000 && {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT} == 3'b000)
      sel_fall_cyc = cyc;
    prev_sel = {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
    if (ROMINIT_VALID === 1'b1) begin
      obs_addr.push_back(ROMINIT_ADDR);
      obs_data.push_back(ROMINIT_DATA);
      obs_sel.push_back({ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] idx);
    DL_INDEX = idx;
    DL_START = 1'b1;
    @(negedge CLK);
    DL_START = 1'b0;
  endtask

  task automatic clearObs();
    obs_addr.delete();
    obs_data.delete();
    obs_sel.delete();
    obs_cyc.delete();
  endtask

  task automatic sendBytes(input int n, input bit gaps, input bit do_end);
    int stall = 0;
    sent = 0;
    max_stall = 0;
    first_acc_cyc = -1;
    while (sent < n && stall <= 100) begin
      DL_DATA  = tx[sent];
      DL_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      DL_END   = do_end && !gaps && (sent == n - 1) && (DL_READY === 1'b1);
      if (DL_VALID && DL_READY === 1'b1) begin
        if (sent == 0) first_acc_cyc = cyc + 1;
        sent++;
        stall = 0;
      end else if (DL_VALID) begin
        stall++;
        if (stall > max_stall) max_stall = stall;
      end
      @(negedge CLK);
    end
    DL_VALID = 1'b0;
    DL_END   = 1'b0;
    if (do_end && (gaps || n == 0)) begin
      DL_END = 1'b1;
      @(negedge CLK);
      DL_END = 1'b0;
    end
  endtask

  task automatic waitResb(input string tag, input int budget);
    int k = 0;
    while (SYS_RESB !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    checkOutput({tag, "_resb_rise"}, SYS_RESB, 1'b1);
  endtask

  task automatic runLoad(input string tag, input logic [1:0] idx, input int n, input bit gaps, input bit seq);
    int limit, kept, bad, min_gap, aw;
    logic [2:0] exp_sel;
    limit   = (idx == 2'd2) ? 131072 : 4096;
    kept    = (n < limit) ? n : limit;
    exp_sel = 3'b001 << idx;
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(seq ? 8'(i) : 8'($urandom));
    clearObs();

    applyStimulus(idx);
    checkOutput({tag, "_busy_after_start"}, BUSY, 1'b1);
    checkOutput({tag, "_err_cleared"}, ERR, 1'b0);
    checkOutput({tag, "_sel_after_start"}, {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT}, exp_sel);
    sendBytes(n, gaps, 1'b1);
    checkOutput({tag, "_bytes_accepted"}, sent, n);
    waitResb(tag, 4 * HOLD_CYCLES + 8 * FIFO_DEPTH * WR_SPACING + 50);

    if (idx == 2'd2 && kept > 0) begin
      aw = 12;
      while (aw < 17 && (1 << aw) < kept) aw++;
      cur_cfg = aw;
    end
    checkOutput({tag, "_cfg_rom_aw"}, CFG_ROM_AW, cur_cfg);
    checkOutput({tag, "_err"}, ERR, (n > limit) ? 1 : 0);
    checkOutput({tag, "_strobe_count"}, obs_addr.size(), kept);
    checkOutput({tag, "_idle_sel"}, {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT}, 3'b000);
    checkOutput({tag, "_idle_busy"}, BUSY, 1'b0);
    checkOutput({tag, "_hold_len"}, rise_cyc - sel_fall_cyc, HOLD_CYCLES);

    bad = -1;
    for (int i = 0; i < obs_addr.size() && i < kept; i++) begin
      if (bad < 0 && (obs_addr[i] !== 25'(i) || obs_data[i] !== tx[i] || obs_sel[i] !== exp_sel)) bad = i;
    end
    if (bad >= 0)
      $display("[TB] %s strobe %0d: addr=%0d data=0x%0h sel=%b", tag, bad, obs_addr[bad], obs_data[bad], obs_sel[bad]);
    checkOutput({tag, "_first_bad_strobe"}, bad, -1);

    if (obs_cyc.size() >= 2) begin
      min_gap = 1 << 30;
      for (int i = 1; i < obs_cyc.size(); i++)
        if (obs_cyc[i] - obs_cyc[i-1] < min_gap) min_gap = obs_cyc[i] - obs_cyc[i-1];
      checkOutput({tag, "_spacing_ok"}, (min_gap >= WR_SPACING) ? 1 : 0, 1);
    end
  endtask

  initial begin
    int n_before;

    // Power-on reset: RES high for three rising edges.
    repeat (3) @(negedge CLK);
    checkOutput("rst_sys_resb", SYS_RESB, 1'b0);
    checkOutput("rst_cfg_aw", CFG_ROM_AW, 5'd13);
    checkOutput("rst_ready", DL_READY, 1'b0);
    checkOutput("rst_valid", ROMINIT_VALID, 1'b0);
    checkOutput("rst_addr", ROMINIT_ADDR, 25'd0);
    checkOutput("rst_busy", BUSY, 1'b0);
    checkOutput("rst_err", ERR, 1'b0);
    RES = 1'b0;
    waitResb("rst", 4 * HOLD_CYCLES);
    checkOutput("rst_hold_len", rise_cyc - last_res_cyc, HOLD_CYCLES);

    // Boot load of 0x00..0x0F with VALID held high.
    runLoad("boot16", 2'd0, 16, 1'b0, 1'b1);
    checkOutput("boot16_first_latency", obs_cyc[0] - first_acc_cyc, 1);
    checkOutput("boot16_ready_throttles", (max_stall >= 1 && max_stall <= WR_SPACING) ? 1 : 0, 1);
    checkOutput("boot16_resb_after_last_strobe", rise_cyc - obs_cyc[obs_cyc.size()-1], HOLD_CYCLES + 1);

    // Invalid region index: error only, no load, READY stays low.
    clearObs();
    applyStimulus(2'd3);
    checkOutput("inv_err", ERR, 1'b1);
    checkOutput("inv_busy", BUSY, 1'b0);
    DL_VALID = 1'b1;
    DL_DATA  = 8'hA5;
    repeat (5) @(negedge CLK);
    checkOutput("inv_ready", DL_READY, 1'b0);
    DL_VALID = 1'b0;
    checkOutput("inv_resb", SYS_RESB, 1'b1);
    checkOutput("inv_no_strobes", obs_addr.size(), 0);
    checkOutput("inv_sel", {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT}, 3'b000);

    // Abort a cart load with RES after 100 accepted bytes.
    tx.delete();
    for (int i = 0; i < 100; i++) tx.push_back(8'($urandom));
    clearObs();
    applyStimulus(2'd2);
    checkOutput("abort_err_cleared", ERR, 1'b0);
    sendBytes(100, 1'b0, 1'b0);
    checkOutput("abort_bytes_accepted", sent, 100);
    RES = 1'b1;
    @(negedge CLK);
    checkOutput("abort_valid_low", ROMINIT_VALID, 1'b0);
    checkOutput("abort_ready_low", DL_READY, 1'b0);
    checkOutput("abort_resb_low", SYS_RESB, 1'b0);
    checkOutput("abort_fifo_empty", dut.u_fifo.empty, 1'b1);
    n_before = obs_addr.size();
    checkOutput("abort_strobes_in_range", (n_before >= 100 - FIFO_DEPTH && n_before <= 100) ? 1 : 0, 1);
    @(negedge CLK);
    RES = 1'b0;
    waitResb("abort", 4 * HOLD_CYCLES);
    checkOutput("abort_hold_len", rise_cyc - last_res_cyc, HOLD_CYCLES);
    checkOutput("abort_no_more_strobes", obs_addr.size(), n_before);
    checkOutput("abort_cfg_unchanged", CFG_ROM_AW, cur_cfg);
    begin
      int bad = -1;
      for (int i = 0; i < obs_addr.size(); i++)
        if (bad < 0 && (obs_addr[i] !== 25'(i) || obs_data[i] !== tx[i] || obs_sel[i] !== 3'b100)) bad = i;
      checkOutput("abort_first_bad_strobe", bad, -1);
    end

    // Cart sizing and region limit cases with random data.
    runLoad("cart8193", 2'd2, 8193, 1'b0, 1'b0);
    runLoad("cart4000", 2'd2, 4000, 1'b0, 1'b0);
    runLoad("cart0", 2'd2, 0, 1'b0, 1'b0);
    runLoad("chr4100", 2'd1, 4100, 1'b0, 1'b0);
    checkOutput("chr4100_last_addr", obs_addr[obs_addr.size()-1], 25'd4095);
    checkOutput("chr4100_no_long_stall", (max_stall <= WR_SPACING) ? 1 : 0, 1);

    // Short random loads with irregular VALID.
    for (int k = 0; k < 4; k++) begin
      runLoad($sformatf("rnd%0d", k), 2'($urandom_range(0, 2)), $urandom_range(1, 40), 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
